// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter: bytes written to DATA are queued in a FIFO
// and sent as 8N1 frames on tx_out; STATUS reports FIFO state and allows flushing.
module uart_tx_fifo #(
    parameter int          SYSTEM_CLK = 50_000_000,
    parameter int          BAUDRATE   = 115200,
    parameter int          DEPTH      = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        is_valid,
    output logic        tx_out,
    output logic        tx_idle
);

    localparam int DIV   = SYSTEM_CLK / BAUDRATE;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [AW:0]      count_q, count_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [7:0]       mem_q [DEPTH];

    logic        empty, full;
    logic        hit_data, hit_stat, req;
    logic        wr_data_req, push, pop, accept, flush;
    logic [7:0]  count8;
    logic [31:0] status;
    logic [23:0] wdata_unused;

    assign wdata_unused = wdata[31:8];

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign hit_data = (addr == BASE_ADDR);
    assign hit_stat = (addr == BASE_ADDR + 32'd4);
    assign is_valid = valid && (hit_data || hit_stat);
    assign req      = is_valid && !ready_q;
    assign tx_idle  = empty && (state_q == S_IDLE);
    assign count8   = 8'(count_q);
    assign status   = {16'h0, count8, 5'h0, tx_idle, full, empty};

    // The serializer pops from IDLE, or at the last STOP cycle to chain frames back-to-back.
    assign pop = !empty && ((state_q == S_IDLE) ||
                            (state_q == S_STOP && cnt_q == '0));

    // A write to a full FIFO can only complete in a cycle where the serializer frees a slot.
    assign wr_data_req = req && hit_data && wstrb[0];
    assign push        = wr_data_req && (!full || pop);
    assign accept      = req && (!wr_data_req || push);
    assign flush       = accept && hit_stat && (wstrb != 4'h0) && wdata[0];

    always_comb begin
        ready_d = accept;
        rdata_d = 32'h0;
        if (accept && hit_stat && wstrb == 4'h0) begin
            rdata_d = status;
        end

        wr_d    = push ? wr_q + AW'(1) : wr_q;
        rd_d    = pop ? rd_q + AW'(1) : rd_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW + 1)'(1);
        end
        if (flush) begin
            count_d = '0;
            rd_d    = wr_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shift_d = mem_q[rd_q];
                    cnt_d   = CNT_MAX;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_MAX;
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_MAX;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    if (pop) begin
                        shift_d = mem_q[rd_q];
                        cnt_d   = CNT_MAX;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase

        // tx_out is registered, so it is derived from the state being entered.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            rdata_q <= 32'h0;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && push) begin
            mem_q[wr_q] <= wdata[7:0];
        end
    end

    assign ready  = ready_q;
    assign rdata  = rdata_q;
    assign tx_out = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: bus driver tasks, a line receiver feeding a
// byte scoreboard, and hand-computed checks of timing and STATUS values.
module tb_uart_tx_fifo;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] STAT = 32'h1000_0004;
    localparam logic [31:0] BAD  = 32'h1000_0008;

    logic        clk;
    logic        resetn;
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        is_valid;
    logic        tx_out;
    logic        tx_idle;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int rx_cnt  = 0;
    logic [7:0] exp_q[$];
    int         rx_start_q[$];

    uart_tx_fifo #(
        .SYSTEM_CLK(1_000_000),
        .BAUDRATE  (100_000),
        .DEPTH     (16),
        .BASE_ADDR (BASE)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .valid   (valid),
        .addr    (addr),
        .wstrb   (wstrb),
        .wdata   (wdata),
        .rdata   (rdata),
        .ready   (ready),
        .is_valid(is_valid),
        .tx_out  (tx_out),
        .tx_idle (tx_idle)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int budget, output int rcyc);
        valid = 1'b1;
        addr  = a;
        wdata = d;
        wstrb = s;
        rcyc  = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                rcyc = cyc;
                break;
            end
        end
        check("wr_ready", {31'h0, ready}, 32'h1);
        valid = 1'b0;
        wstrb = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        valid = 1'b1;
        addr  = a;
        wstrb = 4'h0;
        d     = 32'hdead_beef;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                d = rdata;
                break;
            end
        end
        check("rd_ready", {31'h0, ready}, 32'h1);
        valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (tx_idle) break;
        end
        check("wait_idle", {31'h0, tx_idle}, 32'h1);
    endtask

    // line receiver + scoreboard: samples mid-bit, aborts a frame on reset
    initial begin : rx_proc
        logic [7:0] rb;
        int         st;
        bit         ok;
        forever begin
            @(negedge clk);
            if (resetn && tx_out === 1'b0) begin
                st = cyc;
                ok = 1'b1;
                rb = 8'h0;
                for (int k = 0; k < 100; k++) begin
                    if (k > 0) @(negedge clk);
                    if (!resetn) begin
                        ok = 1'b0;
                        break;
                    end
                    if (k % 10 == 5) begin
                        if (k == 5) check("rx_start_bit", {31'h0, tx_out}, 32'h0);
                        else if (k == 95) check("rx_stop_bit", {31'h0, tx_out}, 32'h1);
                        else rb[k/10 - 1] = tx_out;
                    end
                end
                if (ok) begin
                    rx_cnt++;
                    rx_start_q.push_back(st);
                    if (exp_q.size() == 0) check("rx_extra", {24'h0, rb}, 32'hffff_ffff);
                    else check("rx_byte", {24'h0, rb}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin : main
        logic [31:0] rd;
        int          rc;
        int          base_cnt;
        int          hits;
        logic [7:0]  b;

        resetn = 1'b0;
        valid  = 1'b0;
        addr   = 32'h0;
        wstrb  = 4'h0;
        wdata  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_out", {31'h0, tx_out}, 32'h1);
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_tx_idle", {31'h0, tx_idle}, 32'h1);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        bus_read(STAT, rd);
        check("rst_status", rd, 32'h0000_0005);

        // 1: single frame of 0x55 with exact timing
        exp_q.push_back(8'h55);
        bus_write(BASE, 32'h55, 4'h1, 10, rc);
        @(posedge clk);
        #1;
        check("t1_ready_pulse", {31'h0, ready}, 32'h0);
        check("t1_start_low", {31'h0, tx_out}, 32'h0);
        check("t1_busy", {31'h0, tx_idle}, 32'h0);
        repeat (99) @(posedge clk);
        #1;
        check("t1_last_stop", {31'h0, tx_out}, 32'h1);
        check("t1_still_busy", {31'h0, tx_idle}, 32'h0);
        @(posedge clk);
        #1;
        check("t1_idle_after", {31'h0, tx_idle}, 32'h1);
        check("t1_rx_cnt", rx_cnt, 32'd1);

        // 2: three back-to-back frames, STATUS mid-frame
        rx_start_q = {};
        base_cnt   = rx_cnt;
        for (int i = 0; i < 3; i++) begin
            b = 8'h41 + 8'(i);
            exp_q.push_back(b);
            bus_write(BASE, {24'h0, b}, 4'h1, 10, rc);
        end
        bus_read(STAT, rd);
        check("t2_status_mid", rd, 32'h0000_0200);
        wait_idle(400);
        check("t2_frames", rx_cnt - base_cnt, 32'd3);
        if (rx_start_q.size() == 3) begin
            check("t2_gap01", rx_start_q[1] - rx_start_q[0], 32'd100);
            check("t2_gap12", rx_start_q[2] - rx_start_q[1], 32'd100);
        end else begin
            check("t2_starts", rx_start_q.size(), 32'd3);
        end

        // 3: fill to full, 18th write stalls until the first frame's last STOP cycle
        rx_start_q = {};
        base_cnt   = rx_cnt;
        for (int i = 0; i < 17; i++) begin
            b = 8'h10 + 8'(i);
            exp_q.push_back(b);
            bus_write(BASE, {24'h0, b}, 4'h1, 10, rc);
        end
        bus_read(STAT, rd);
        check("t3_status_full", rd, 32'h0000_1002);
        exp_q.push_back(8'hc3);
        bus_write(BASE, 32'hc3, 4'h1, 200, rc);
        if (rx_start_q.size() > 0) check("t3_stall_release", rc, rx_start_q[0] + 100);
        else check("t3_first_frame", rx_start_q.size(), 32'd1);
        wait_idle(2500);
        check("t3_frames", rx_cnt - base_cnt, 32'd18);

        // 4: flush with bytes queued; only the in-flight frame goes out
        base_cnt = rx_cnt;
        exp_q.push_back(8'h31);
        for (int i = 0; i < 5; i++) bus_write(BASE, 32'h31 + i, 4'h1, 10, rc);
        bus_write(STAT, 32'h1, 4'hf, 10, rc);
        wait_idle(200);
        repeat (150) @(posedge clk);
        #1;
        bus_read(STAT, rd);
        check("t4_status", rd, 32'h0000_0005);
        check("t4_frames", rx_cnt - base_cnt, 32'd1);

        // 5: reset in the middle of frame 2 of 4
        base_cnt = rx_cnt;
        exp_q.push_back(8'ha1);
        for (int i = 0; i < 4; i++) bus_write(BASE, 32'ha1 + i, 4'h1, 10, rc);
        repeat (140) @(posedge clk);
        #1;
        check("t5_mid_frame2", {31'h0, tx_idle}, 32'h0);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("t5_tx_high", {31'h0, tx_out}, 32'h1);
        check("t5_ready_low", {31'h0, ready}, 32'h0);
        resetn = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        bus_read(STAT, rd);
        check("t5_status", rd, 32'h0000_0005);
        check("t5_frames", rx_cnt - base_cnt, 32'd1);

        // 6: unmatched address, DATA read, DATA write without byte strobe
        base_cnt = rx_cnt;
        hits     = 0;
        valid    = 1'b1;
        addr     = BAD;
        wstrb    = 4'h1;
        wdata    = 32'h77;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 10) wstrb = 4'h0;
            if (is_valid || ready) hits++;
        end
        valid = 1'b0;
        check("t6_bad_hits", hits, 32'd0);
        bus_read(STAT, rd);
        check("t6_status", rd, 32'h0000_0005);
        bus_read(BASE, rd);
        check("t6_data_rd", rd, 32'h0);
        bus_write(BASE, 32'h99, 4'h2, 10, rc);
        bus_read(STAT, rd);
        check("t6_nostrb_status", rd, 32'h0000_0005);
        repeat (120) @(posedge clk);
        #1;
        check("t6_frames", rx_cnt - base_cnt, 32'd0);
        check("exp_q_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
FIFO-buffered, memory-mapped UART transmitter for the SoC I/O region. It replaces the per-byte busy-wait on the bare serializer. It is a bus slave on the CPU valid/ready memory interface: it accepts bytes into a DEPTH-entry FIFO and drains them as 8N1 frames on tx_out. It also exposes a status/control register for polling, flushing and end-of-transmission detection.

Parameters:
SYSTEM_CLK, 50_000_000, clock frequency in Hz
BAUDRATE, 115200, line rate; DIV = SYSTEM_CLK/BAUDRATE cycles per bit (integer division, DIV >= 2)
DEPTH, 16, FIFO entries, power of 2, >= 2
BASE_ADDR, 32'h1000_0000, DATA register address; STATUS register is at BASE_ADDR+4

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
valid  in  1  CPU request valid, held until ready
addr  in  32  byte address
wstrb  in  4  write strobes; zero means read
wdata  in  32  write data
rdata  out  32  read data, valid only while ready=1, else 0
ready  out  1  one-cycle completion pulse
is_valid  out  1  combinational: valid && addr matches DATA or STATUS
tx_out  out  1  serial line, idle high
tx_idle  out  1  FIFO empty and serializer in IDLE (usable as interrupt level)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on resetn.
- Reset values: tx_out=1, ready=0, rdata=0, FIFO count=0, rd/wr pointers=0, serializer=IDLE, tx_idle=1.
- Handshake:
  - A request is accepted when is_valid && !ready and the access can complete this cycle.
  - ready is asserted the following cycle for exactly one cycle.
  - The master drops valid or changes address after ready. The block never accepts in a cycle where ready=1.
- DATA write (wstrb[0]=1):
  - Not full: push wdata[7:0]; ready next cycle.
  - Full: stall, so ready is withheld and valid held. The push completes in the first cycle a pop occurs (push and pop coexist, count unchanged); ready follows one cycle later.
  - Writes with wstrb[0]=0 to DATA complete without a push.
- DATA read: completes in 1 cycle, rdata=0.
- STATUS read: completes in 1 cycle. Fields:
  - bit0 = empty
  - bit1 = full
  - bit2 = tx_idle
  - bits[15:8] = count (zero-extended)
  - all other bits 0
- STATUS write: completes in 1 cycle.
  - wdata[0]=1 flushes the FIFO: count=0, rd=wr pointer.
  - A frame already in the shifter completes normally.
  - A pop in the flush cycle still delivers the head byte.
- FIFO:
  - count is log2(DEPTH)+1 bits; pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Push when full (without a simultaneous pop) and pop when empty never happen.
- Serializer FSM: IDLE -> START -> DATA -> STOP.
  - IDLE: tx_out=1. If FIFO is non-empty, pop the head into the shift register and go to START the next cycle.
  - START: tx_out=0 for DIV cycles.
  - DATA: 8 bits, LSB first, each DIV cycles; a 3-bit bit index counts 0..7.
  - STOP: tx_out=1 for DIV cycles. At the last STOP cycle, if FIFO is non-empty, pop and go directly to START with no idle gap; else go to IDLE.
  - Frame length is exactly 10*DIV cycles.
- Bit counter: a down-counter of width clog2(DIV), reloaded to DIV-1 on every bit boundary.
- tx_idle: combinational from FIFO empty and FSM==IDLE.
- Reset mid-frame: tx_out=1 the cycle after reset is sampled low; FIFO is emptied; any pending stalled write is dropped (ready stays 0).
- Unmatched address: is_valid=0, ready never asserts, no state change.

Test Plan:
Parameters for all scenarios: SYSTEM_CLK=1_000_000, BAUDRATE=100_000 (DIV=10), DEPTH=16, BASE_ADDR=0x1000_0000.
1. Write 0x55 to 0x1000_0000 from idle -> ready 1 cycle later. tx_out is low for 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then high for 10 cycles; tx_idle returns to 1 exactly 100 cycles after frame start plus IDLE pop latency.
2. Write 0x41,0x42,0x43 back-to-back -> three contiguous frames with no idle gap, 300 cycles total. A STATUS read mid-first-frame returns 0x0000_0200 (count=2, bits 2:0=000).
3. Issue 18 writes back-to-back -> writes 1-17 complete (one byte is in the shifter, 16 in FIFO). STATUS shows full. Write 18 stalls until the first frame's last STOP cycle, then ready asserts one cycle later.
4. Queue 5 bytes, write 0x1 to 0x1000_0004 -> the in-flight frame completes and no further frames are sent. STATUS then reads 0x0000_0005 (empty, idle).
5. Assert resetn=0 for 1 cycle in the middle of frame 2 of 4 -> tx_out=1 the next cycle. STATUS reads 0x0000_0005 and no frames follow.
6. Read/write to 0x1000_0008 -> is_valid=0, ready stays 0 for 20 cycles, FIFO count unchanged.
